// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the 5-stage pipeline controller: FSM states and the
// per-stage enable/flush bundle, plus the two canned control patterns.
package pipeline_ctrl_pkg;

   localparam int REG_W = 5;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } pctrl_state_t;

   typedef struct packed {
      logic pc_en;
      logic ifid_en;
      logic ifid_flush;
      logic idex_en;
      logic idex_flush;
      logic exmem_en;
      logic exmem_flush;
      logic memwb_en;
   } pipe_ctl_t;

   localparam pipe_ctl_t CTL_FREEZE = '{default: 1'b0};

   localparam pipe_ctl_t CTL_RUN = '{
      pc_en:       1'b1,
      ifid_en:     1'b1,
      ifid_flush:  1'b0,
      idex_en:     1'b1,
      idex_flush:  1'b0,
      exmem_en:    1'b1,
      exmem_flush: 1'b0,
      memwb_en:    1'b1
   };

   // Even parity over a control bundle, for use by downstream checkers.
   function automatic logic ctl_parity(input pipe_ctl_t ctl);
      return ^ctl;
   endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard compare: the ID/EX load's destination matches a source of
// the instruction in IF/ID. Register r0 never creates a dependency.
module hazard_detect
   import pipeline_ctrl_pkg::*;
(
   input  logic             ex_dREN,
   input  logic [REG_W-1:0] ex_wsel,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   output logic             lduse
);

   logic wsel_nz_s;
   logic match_s;

   // Destination/source comparison with r0 excluded.
   always_comb begin
      wsel_nz_s = (ex_wsel != {REG_W{1'b0}});
      match_s   = (ex_wsel == id_rs) || (ex_wsel == id_rt);
      lduse     = ex_dREN && wsel_nz_s && match_s;
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: stage enables and
// flushes, halt drain FSM, saturating stall counter and D-memory watchdog.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int CNT_W   = 32,
   parameter int TIMEOUT = 1024
)(
   input  logic             CLK,
   input  logic             nRST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic             mem_dreq,
   input  logic             mem_halt,
   input  logic             ex_dREN,
   input  logic [REG_W-1:0] ex_wsel,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             br_taken,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             ifid_flush,
   output logic             idex_en,
   output logic             idex_flush,
   output logic             exmem_en,
   output logic             exmem_flush,
   output logic             memwb_en,
   output logic             halted,
   output logic             err,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam int            DW         = $clog2(TIMEOUT) + 1;
   localparam logic [DW-1:0] TMO_C      = DW'(TIMEOUT);
   localparam logic [DW-1:0] TMO_M1_C   = DW'(TIMEOUT - 1);

   pctrl_state_t     state_r;
   pctrl_state_t     next_state_s;
   pipe_ctl_t        ctl_s;
   pipe_ctl_t        ctl_out_s;
   logic             lduse_s;
   logic             dwait_s;
   logic [CNT_W-1:0] stall_cnt_r;
   logic [DW-1:0]    dwait_cnt_r;
   logic             err_r;
   logic             halted_r;

   hazard_detect u_hazard (
      .ex_dREN (ex_dREN),
      .ex_wsel (ex_wsel),
      .id_rs   (id_rs),
      .id_rt   (id_rt),
      .lduse   (lduse_s)
   );

   assign dwait_s = mem_dreq && !dhit;

   // Priority arbitration of stall/flush sources and next-state selection.
   always_comb begin
      ctl_s        = CTL_RUN;
      next_state_s = state_r;
      case (state_r)
         RUN: begin
            if (dwait_s) begin
               ctl_s = CTL_FREEZE;
            end else if (mem_halt) begin
               // Everything behind halt is discarded before it reaches MEM.
               ctl_s             = CTL_FREEZE;
               ctl_s.memwb_en    = 1'b1;
               ctl_s.exmem_flush = 1'b1;
               next_state_s      = DRAIN;
            end else if (br_taken) begin
               ctl_s.pc_en      = ihit;
               ctl_s.ifid_flush = 1'b1;
               ctl_s.idex_flush = 1'b1;
            end else if (lduse_s) begin
               ctl_s.pc_en      = 1'b0;
               ctl_s.ifid_en    = 1'b0;
               ctl_s.idex_flush = 1'b1;
            end else if (!ihit) begin
               ctl_s.pc_en      = 1'b0;
               ctl_s.ifid_flush = 1'b1;
            end else begin
               ctl_s = CTL_RUN;
            end
         end
         DRAIN: begin
            ctl_s          = CTL_FREEZE;
            ctl_s.memwb_en = 1'b1;
            next_state_s   = HALTED;
         end
         HALTED: begin
            ctl_s = CTL_FREEZE;
         end
         default: begin
            ctl_s        = CTL_FREEZE;
            next_state_s = RUN;
         end
      endcase
   end

   // Hold every stage still while reset is asserted.
   always_comb begin
      if (!nRST) begin
         ctl_out_s = CTL_FREEZE;
      end else begin
         ctl_out_s = ctl_s;
      end
   end

   // FSM state, halted flag, stall counter and D-memory watchdog.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_r     <= RUN;
         halted_r    <= 1'b0;
         stall_cnt_r <= {CNT_W{1'b0}};
         dwait_cnt_r <= {DW{1'b0}};
         err_r       <= 1'b0;
      end else begin
         state_r <= next_state_s;
         if (state_r == DRAIN) begin
            halted_r <= 1'b1;
         end
         if ((state_r == RUN) && !ctl_s.pc_en && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + CNT_W'(1);
         end
         if ((state_r == RUN) && dwait_s) begin
            if (dwait_cnt_r != TMO_C) begin
               dwait_cnt_r <= dwait_cnt_r + DW'(1);
            end
            // Flag on the same edge the count reaches the limit.
            if (dwait_cnt_r >= TMO_M1_C) begin
               err_r <= 1'b1;
            end
         end else begin
            dwait_cnt_r <= {DW{1'b0}};
         end
      end
   end

   assign pc_en       = ctl_out_s.pc_en;
   assign ifid_en     = ctl_out_s.ifid_en;
   assign ifid_flush  = ctl_out_s.ifid_flush;
   assign idex_en     = ctl_out_s.idex_en;
   assign idex_flush  = ctl_out_s.idex_flush;
   assign exmem_en    = ctl_out_s.exmem_en;
   assign exmem_flush = ctl_out_s.exmem_flush;
   assign memwb_en    = ctl_out_s.memwb_en;
   assign halted      = halted_r;
   assign err         = err_r;
   assign stall_cnt   = stall_cnt_r;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl (CNT_W=4, TIMEOUT=4).
module tb_pipeline_ctrl;

   logic       CLK = 1'b0;
   logic       nRST;
   logic       ihit, dhit, mem_dreq, mem_halt, ex_dREN, br_taken;
   logic [4:0] ex_wsel, id_rs, id_rt;
   logic       pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
   logic       exmem_en, exmem_flush, memwb_en, halted, err;
   logic [3:0] stall_cnt;
   logic [7:0] ctl;

   int n_cmp = 0;
   int n_bad = 0;

   // Control patterns, bit order: pc,ifid_en,ifid_fl,idex_en,idex_fl,exmem_en,exmem_fl,memwb
   localparam logic [7:0] C_RUN  = 8'b1101_0101;
   localparam logic [7:0] C_FRZ  = 8'b0000_0000;
   localparam logic [7:0] C_BR   = 8'b1111_1101;
   localparam logic [7:0] C_BRNI = 8'b0111_1101;
   localparam logic [7:0] C_LDU  = 8'b0001_1101;
   localparam logic [7:0] C_IMIS = 8'b0111_0101;
   localparam logic [7:0] C_HLT  = 8'b0000_0011;
   localparam logic [7:0] C_DRN  = 8'b0000_0001;

   pipeline_ctrl #(.CNT_W(4), .TIMEOUT(4)) dut (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_dreq(mem_dreq),
      .mem_halt(mem_halt), .ex_dREN(ex_dREN), .ex_wsel(ex_wsel), .id_rs(id_rs),
      .id_rt(id_rt), .br_taken(br_taken), .pc_en(pc_en), .ifid_en(ifid_en),
      .ifid_flush(ifid_flush), .idex_en(idex_en), .idex_flush(idex_flush),
      .exmem_en(exmem_en), .exmem_flush(exmem_flush), .memwb_en(memwb_en),
      .halted(halted), .err(err), .stall_cnt(stall_cnt)
   );

   always #5 CLK = ~CLK;

   assign ctl = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic idle();
      ihit = 1'b1; dhit = 1'b0; mem_dreq = 1'b0; mem_halt = 1'b0;
      ex_dREN = 1'b0; br_taken = 1'b0; ex_wsel = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
   endtask

   // Advance to just after the next rising edge.
   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      nRST = 1'b0;
      idle();
      #3;
      check("rst_ctl", 32'(ctl), 32'(C_FRZ));
      check("rst_halted", 32'(halted), 32'd0);
      check("rst_stall", 32'(stall_cnt), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      #4 nRST = 1'b1;
      cyc();

      #1 check("run_ctl", 32'(ctl), 32'(C_RUN));
      cyc(); check("run_stall", 32'(stall_cnt), 32'd0);

      ex_dREN = 1'b1; ex_wsel = 5'd5; id_rt = 5'd5;
      #1 check("lduse_ctl", 32'(ctl), 32'(C_LDU));
      cyc(); check("lduse_stall", 32'(stall_cnt), 32'd1);

      ex_wsel = 5'd0; id_rt = 5'd0;
      #1 check("lduse_r0_ctl", 32'(ctl), 32'(C_RUN));
      cyc(); check("lduse_r0_stall", 32'(stall_cnt), 32'd1);

      ex_wsel = 5'd5; id_rs = 5'd5; br_taken = 1'b1;
      #1 check("br_over_lduse", 32'(ctl), 32'(C_BR));
      cyc(); check("br_stall", 32'(stall_cnt), 32'd1);

      idle(); br_taken = 1'b1; ihit = 1'b0;
      #1 check("br_noihit", 32'(ctl), 32'(C_BRNI));
      cyc(); check("br_noihit_stall", 32'(stall_cnt), 32'd2);

      idle(); ihit = 1'b0;
      #1 check("imiss_ctl", 32'(ctl), 32'(C_IMIS));
      cyc(); check("imiss_stall", 32'(stall_cnt), 32'd3);

      idle(); mem_dreq = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1 check("dmiss_ctl", 32'(ctl), 32'(C_FRZ));
         cyc();
      end
      check("dmiss_stall", 32'(stall_cnt), 32'd6);
      check("dmiss3_err", 32'(err), 32'd0);
      dhit = 1'b1;
      #1 check("dhit_ctl", 32'(ctl), 32'(C_RUN));
      cyc(); check("dhit_stall", 32'(stall_cnt), 32'd6);

      dhit = 1'b0;
      for (int i = 0; i < 4; i++) cyc();
      check("tmo_err", 32'(err), 32'd1);
      check("tmo_stall", 32'(stall_cnt), 32'd10);
      dhit = 1'b1;
      #1 check("tmo_release_ctl", 32'(ctl), 32'(C_RUN));
      cyc();
      idle(); cyc();
      check("err_sticky", 32'(err), 32'd1);

      mem_halt = 1'b1; mem_dreq = 1'b1;
      #1 check("halt_wait_ctl", 32'(ctl), 32'(C_FRZ));
      cyc(); check("halt_wait_stall", 32'(stall_cnt), 32'd11);
      dhit = 1'b1;
      #1 check("halt_trans_ctl", 32'(ctl), 32'(C_HLT));
      cyc(); check("halt_trans_stall", 32'(stall_cnt), 32'd12);
      idle();
      #1 check("drain_ctl", 32'(ctl), 32'(C_DRN));
      check("drain_halted", 32'(halted), 32'd0);
      cyc();
      for (int i = 0; i < 3; i++) begin
         #1 check("halted_ctl", 32'(ctl), 32'(C_FRZ));
         check("halted_flag", 32'(halted), 32'd1);
         cyc();
      end
      check("halted_stall", 32'(stall_cnt), 32'd12);

      nRST = 1'b0;
      #2 check("rst2_ctl", 32'(ctl), 32'(C_FRZ));
      check("rst2_halted", 32'(halted), 32'd0);
      check("rst2_stall", 32'(stall_cnt), 32'd0);
      check("rst2_err", 32'(err), 32'd0);
      nRST = 1'b1;
      #1 check("rst2_run_ctl", 32'(ctl), 32'(C_RUN));
      cyc();

      ihit = 1'b0;
      for (int i = 0; i < 15; i++) cyc();
      check("sat15_stall", 32'(stall_cnt), 32'd15);
      for (int i = 0; i < 5; i++) cyc();
      check("sat20_stall", 32'(stall_cnt), 32'd15);
      check("sat_ctl", 32'(ctl), 32'(C_IMIS));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
